// File: rtl/cu_isa_pkg.sv
// cu_isa_pkg: compute-unit ISA constants, instruction field positions and sequencer states
package cu_isa_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int TGT_HI  = 11;
  localparam int TGT_LO  = 8;
  localparam int SRC0_HI = 7;
  localparam int SRC0_LO = 4;
  localparam int SRC1_HI = 3;
  localparam int SRC1_LO = 0;
  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 8;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// prog_mem: DEPTH x 16 program store, synchronous write, combinational read
// ports: clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata read port
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [PC_W-1:0] i_waddr,
  input  logic [15:0]     i_wdata,
  input  logic [PC_W-1:0] i_raddr,
  output logic [15:0]     o_rdata
);
  logic [15:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: loads a byte-wise program and issues it one instruction at a time to the compute unit
// ports: clk, rst (sync, active-high); ld_valid/ld_byte/ld_clear program load;
//        start run request; instr_out/instr_valid/instr_ready issue handshake;
//        result_in/result_valid result return; last_result, pc, busy, done, err status
module instr_sequencer
  import cu_isa_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  input  logic [7:0]      ld_byte,
  input  logic            ld_clear,
  input  logic            start,
  output logic [15:0]     instr_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic [7:0]      result_in,
  input  logic            result_valid,
  output logic [7:0]      last_result,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t          r_state;
  logic [PC_W-1:0] r_wr_ptr, r_pc;
  logic [PC_W:0]   r_prog_len;
  logic            r_phase_lo, r_err;
  logic [7:0]      r_hi, r_last;
  logic [TW-1:0]   r_cnt;
  logic [15:0]     w_rd;
  logic            w_idle, w_full, w_halt, w_we, w_last_instr;
  assign w_idle       = r_state == S_IDLE;
  assign w_full       = r_prog_len == (PC_W+1)'(DEPTH);
  assign w_halt       = w_rd[OP_HI:OP_LO] == OP_HALT;
  assign w_we         = w_idle && !start && !ld_clear && ld_valid && r_phase_lo && !w_full;
  assign w_last_instr = {1'b0, r_pc} == r_prog_len - (PC_W+1)'(1);
  assign instr_valid  = r_state == S_ISSUE && !w_halt;
  assign instr_out    = instr_valid ? w_rd : '0;
  assign busy         = r_state == S_ISSUE || r_state == S_WAIT;
  assign done         = r_state == S_DONE;
  assign last_result  = r_last;
  assign pc           = r_pc;
  assign err          = r_err;
  prog_mem #(.DEPTH(DEPTH), .PC_W(PC_W)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata ({r_hi, ld_byte}),
    .i_raddr (r_pc),
    .o_rdata (w_rd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_phase_lo <= 1'b0;
      r_hi       <= '0;
      r_pc       <= '0;
      r_last     <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (ld_valid && !w_idle) r_err <= 1'b1;
      case (r_state)
        S_IDLE:
          if (start) begin
            // a same-cycle byte or a dangling high byte is lost and flagged
            r_err      <= r_err | ld_valid | r_phase_lo;
            r_phase_lo <= 1'b0;
            if (r_prog_len == '0) r_state <= S_DONE;
            else begin
              r_pc    <= '0;
              r_state <= S_ISSUE;
            end
          end else if (ld_clear) begin
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
            r_phase_lo <= 1'b0;
            r_err      <= 1'b0;
          end else if (ld_valid) begin
            if (w_full) r_err <= 1'b1;
            else if (!r_phase_lo) begin
              r_hi       <= ld_byte;
              r_phase_lo <= 1'b1;
            end else begin
              r_phase_lo <= 1'b0;
              r_wr_ptr   <= r_wr_ptr + PC_W'(1);
              r_prog_len <= r_prog_len + (PC_W+1)'(1);
            end
          end
        S_ISSUE:
          if (w_halt) r_state <= S_DONE;
          else if (instr_ready) begin
            r_state <= S_WAIT;
            r_cnt   <= TW'(TIMEOUT);
          end
        S_WAIT:
          if (result_valid) begin
            r_last <= result_in;
            if (w_last_instr) r_state <= S_DONE;
            else begin
              r_pc    <= r_pc + PC_W'(1);
              r_state <= S_ISSUE;
            end
          end else if (r_cnt == TW'(1)) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else r_cnt <= r_cnt - TW'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized self-checking bench against a queue-based program model
module tb_instr_sequencer;
  localparam int TIMEOUT = 15;
  logic        clk = 0, rst = 1, ld_valid = 0, ld_clear = 0, start = 0;
  logic        instr_ready = 0, result_valid = 0;
  logic [7:0]  ld_byte = 0, result_in = 0;
  logic [15:0] instr_out;
  logic        instr_valid, busy, done, err;
  logic [7:0]  last_result;
  logic [3:0]  pc;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] m_prog[$];
  logic [7:0]  res_q[$];
  logic        m_phase = 0, m_err = 0;
  logic [7:0]  m_hi = 0, m_last = 0;
  int          m_pc = 0;
  instr_sequencer #(.DEPTH(16), .PC_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_clear(ld_clear),
    .start(start), .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .result_in(result_in), .result_valid(result_valid), .last_result(last_result),
    .pc(pc), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic ld_b(input logic [7:0] b);
    ld_valid = 1;
    ld_byte = b;
    @(negedge clk);
    ld_valid = 0;
    if (m_prog.size() == 16) m_err = 1;
    else if (!m_phase) begin
      m_hi = b;
      m_phase = 1;
    end else begin
      m_prog.push_back({m_hi, b});
      m_phase = 0;
    end
  endtask
  task automatic ld_w(input logic [15:0] w);
    ld_b(w[15:8]);
    ld_b(w[7:0]);
  endtask
  task automatic clr;
    ld_clear = 1;
    @(negedge clk);
    ld_clear = 0;
    m_prog.delete();
    m_phase = 0;
    m_err = 0;
  endtask
  // to_mode: 0 never time out, 1 occasionally, 2 always
  task automatic run_prog(input int rdy_min, input int rdy_max, input int dd_max,
                          input int to_mode, input bit with_ld);
    int i, rd, dd;
    bit fin;
    logic [7:0] r;
    start = 1;
    ld_valid = with_ld;
    ld_byte = 8'hAA;
    @(negedge clk);
    start = 0;
    ld_valid = 0;
    if (m_phase || with_ld) m_err = 1;
    m_phase = 0;
    fin = m_prog.size() == 0;
    if (!fin) m_pc = 0;
    i = 0;
    while (!fin) begin
      if (m_prog[i][15:12] == 4'hF) begin
        chk("halt_valid", instr_valid, 0);
        chk("halt_busy", busy, 1);
        m_pc = i;
        @(negedge clk);
        fin = 1;
      end else begin
        chk("valid", instr_valid, 1);
        chk("instr", instr_out, m_prog[i]);
        rd = $urandom_range(rdy_min, rdy_max);
        repeat (rd) begin
          result_valid = 1'($urandom_range(0, 1));
          result_in = 8'($urandom);
          @(negedge clk);
          chk("hold_valid", instr_valid, 1);
          chk("hold_instr", instr_out, m_prog[i]);
        end
        result_valid = 0;
        instr_ready = 1;
        @(negedge clk);
        instr_ready = 0;
        chk("post_hs_valid", instr_valid, 0);
        chk("post_hs_busy", busy, 1);
        chk("stray_res", last_result, m_last);
        m_pc = i;
        dd = (to_mode == 2 || (to_mode == 1 && $urandom_range(0, 7) == 0)) ? TIMEOUT + 1
                                                                           : $urandom_range(1, dd_max);
        if (dd > TIMEOUT) begin
          repeat (TIMEOUT - 1) @(negedge clk);
          chk("pre_to_err", err, m_err);
          chk("pre_to_done", done, 0);
          @(negedge clk);
          m_err = 1;
          fin = 1;
        end else begin
          repeat (dd - 1) @(negedge clk);
          r = res_q.size() > 0 ? res_q.pop_front() : 8'($urandom);
          result_valid = 1;
          result_in = r;
          @(negedge clk);
          result_valid = 0;
          m_last = r;
          if (i == m_prog.size() - 1) fin = 1;
          else i++;
        end
      end
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", instr_valid, 0);
    chk("pc", pc, 32'(m_pc));
    chk("err", err, m_err);
    chk("last", last_result, m_last);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_instr", instr_out, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_last", last_result, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 0;
    @(negedge clk);
    ld_w(16'h1305);
    ld_w(16'h1203);
    ld_w(16'h2123);
    res_q = '{8'h05, 8'h03, 8'h08};
    run_prog(0, 0, 1, 0, 0);
    chk("basic_last", last_result, 8'h08);
    chk("basic_pc", pc, 2);
    chk("basic_err", err, 0);
    clr;
    ld_w(16'h1107);
    ld_w(16'hF000);
    ld_w(16'h1209);
    res_q = '{8'h07};
    run_prog(0, 0, 1, 0, 0);
    chk("halt_last", last_result, 8'h07);
    chk("halt_pc", pc, 1);
    clr;
    ld_w(16'h1305);
    ld_w(16'h1203);
    run_prog(5, 5, 2, 0, 0);
    clr;
    ld_w(16'h1305);
    run_prog(0, 1, 1, 2, 0);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    clr;
    for (int k = 0; k < 16; k++) ld_w({4'($urandom_range(1, 7)), 12'($urandom)});
    chk("full_err", err, 0);
    ld_w(16'h1FFF);
    chk("ovf_err", err, 1);
    run_prog(0, 0, 1, 0, 0);
    chk("ovf_pc", pc, 15);
    clr;
    chk("clr_err", err, 0);
    run_prog(0, 0, 1, 0, 0);
    ld_w(16'h1305);
    ld_w(16'h2123);
    start = 1;
    @(negedge clk);
    start = 0;
    m_pc = 0;
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
    chk("mid_busy", busy, 1);
    ld_valid = 1;
    ld_byte = 8'h55;
    @(negedge clk);
    ld_valid = 0;
    chk("run_ld_err", err, 1);
    rst = 1;
    @(negedge clk);
    chk("mr_instr", instr_out, 0);
    chk("mr_valid", instr_valid, 0);
    chk("mr_last", last_result, 0);
    chk("mr_pc", pc, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    rst = 0;
    m_prog.delete();
    m_phase = 0;
    m_err = 0;
    m_last = 0;
    m_pc = 0;
    run_prog(0, 0, 1, 0, 0);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) clr;
      for (int w = $urandom_range(0, 5); w > 0; w--)
        ld_w({($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7)), 12'($urandom)});
      if ($urandom_range(0, 5) == 0) ld_b(8'($urandom));
      run_prog(0, 3, 4, 1, $urandom_range(0, 7) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
